// File: rtl/psi_inv_gen_pkg.sv
// Shared defaults, generator FSM states and conditional-subtract modular helpers.
// The helpers work on 32-bit values; operands must be below 2^31 and below q.
package psi_inv_gen_pkg;

   localparam int unsigned DefWidth = 17;
   localparam int unsigned DefQ     = 7681;
   localparam int unsigned DefN     = 64;
   localparam int unsigned DefIdxw  = $clog2(DefN);
   localparam int unsigned MaxW     = 32;

   typedef enum logic [1:0] {StIdle, StEmit, StMul} gen_state_e;

   function automatic logic [MaxW-1:0] mod_add(input logic [MaxW-1:0] a,
                                                input logic [MaxW-1:0] b,
                                                input logic [MaxW-1:0] q);
      logic [MaxW-1:0] s;
      s = a + b;
      return (s >= q) ? s - q : s;
   endfunction

   function automatic logic [MaxW-1:0] mod_dbl(input logic [MaxW-1:0] a,
                                                input logic [MaxW-1:0] q);
      return mod_add(a, a, q);
   endfunction

endpackage

// File: rtl/psi_inv_gen_if.sv
// Valid/ready stream carrying one twiddle power and its index tag.
interface psi_inv_gen_if
   import psi_inv_gen_pkg::*;
#(
   parameter int unsigned WIDTH = DefWidth,
   parameter int unsigned IDXW  = DefIdxw
) ();

   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [IDXW-1:0]  out_idx;

   modport master (output out_valid, output out_data, output out_idx, input out_ready);
   modport slave  (input out_valid, input out_data, input out_idx, output out_ready);

endinterface

// File: rtl/psi_inv_gen_mod_mul_serial.sv
// Bit-serial modular multiplier, MSB first, one multiplier bit per cycle (WIDTH cycles).
// done_o and result_o are combinational so the caller can take the product on the last step.
module psi_inv_gen_mod_mul_serial
   import psi_inv_gen_pkg::*;
#(
   parameter int unsigned WIDTH = DefWidth,
   parameter int unsigned Q     = DefQ
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic [WIDTH-1:0] result_o,
   output logic             done_o
);

   localparam int unsigned CntW = $clog2(WIDTH);

   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] p_q, p_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic [MaxW-1:0]  dbl;
   logic [MaxW-1:0]  sum;
   logic             unused_hi;

   assign dbl       = mod_dbl(MaxW'(p_q), MaxW'(Q));
   assign sum       = mod_add(dbl, MaxW'(a_q), MaxW'(Q));
   assign unused_hi = ^{dbl[MaxW-1:WIDTH], sum[MaxW-1:WIDTH]};

   always_comb begin
      a_d    = a_q;
      b_d    = b_q;
      p_d    = p_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      done_o = 1'b0;
      if (load_i) begin
         a_d    = a_i;
         b_d    = b_i;
         p_d    = '0;
         cnt_d  = CntW'(WIDTH - 1);
         busy_d = 1'b1;
      end else if (busy_q) begin
         p_d   = b_q[WIDTH-1] ? sum[WIDTH-1:0] : dbl[WIDTH-1:0];
         b_d   = b_q << 1;
         cnt_d = cnt_q - CntW'(1);
         if (cnt_q == '0) begin
            busy_d = 1'b0;
            done_o = 1'b1;
         end
      end
      result_o = p_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q    <= '0;
         b_q    <= '0;
         p_q    <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         a_q    <= a_d;
         b_q    <= b_d;
         p_q    <= p_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

   assign busy_o = busy_q;

endmodule

// File: rtl/psi_inv_gen.sv
// Run-time generator of psi_inv^k mod Q, k = 0..N-1, streamed with an index tag.
// Each power after the first costs one handshake cycle plus WIDTH multiplier cycles.
module psi_inv_gen
   import psi_inv_gen_pkg::*;
#(
   parameter int unsigned WIDTH = DefWidth,
   parameter int unsigned Q     = DefQ,
   parameter int unsigned N     = DefN
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [WIDTH-1:0] psi_inv_i,
   psi_inv_gen_if.master    out_if,
   output logic             busy_o,
   output logic             done_o
);

   localparam int unsigned IDXW = $clog2(N);

   gen_state_e       state_q, state_d;
   logic [WIDTH-1:0] base_q, base_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic             done_q, done_d;
   logic             mul_load;
   logic             mul_done;
   logic [WIDTH-1:0] mul_result;
   logic             unused_mul_busy;

   psi_inv_gen_mod_mul_serial #(
      .WIDTH (WIDTH),
      .Q     (Q)
   ) u_mul (
      .clk      (clk),
      .rst      (rst),
      .load_i   (mul_load),
      .a_i      (acc_q),
      .b_i      (base_q),
      .busy_o   (unused_mul_busy),
      .result_o (mul_result),
      .done_o   (mul_done)
   );

   always_comb begin
      state_d  = state_q;
      base_d   = base_q;
      acc_d    = acc_q;
      idx_d    = idx_q;
      done_d   = 1'b0;
      mul_load = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               base_d  = psi_inv_i;
               acc_d   = WIDTH'(1);
               idx_d   = '0;
               state_d = StEmit;
            end
         end
         StEmit: begin
            if (out_if.out_ready) begin
               if (idx_q == IDXW'(N - 1)) begin
                  state_d = StIdle;
                  done_d  = 1'b1;
               end else begin
                  idx_d    = idx_q + IDXW'(1);
                  mul_load = 1'b1;
                  state_d  = StMul;
               end
            end
         end
         StMul: begin
            if (mul_done) begin
               acc_d   = mul_result;
               state_d = StEmit;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         base_q  <= '0;
         acc_q   <= '0;
         idx_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         acc_q   <= acc_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
      end
   end

   // Outputs come straight from registers: no path from out_ready to out_valid.
   assign out_if.out_valid = (state_q == StEmit);
   assign out_if.out_data  = acc_q;
   assign out_if.out_idx   = idx_q;
   assign busy_o           = (state_q != StIdle);
   assign done_o           = done_q;

endmodule

// File: tb/tb_psi_inv_gen.sv
// Bench for psi_inv_gen: a small (Q=17, N=8) and a default-sized (Q=7681, N=64) instance.
module tb_psi_inv_gen;

   localparam int unsigned AW = 5, AQ = 17, AN = 8, AIW = 3;
   localparam int unsigned BW = 17, BQ = 7681, BN = 64, BIW = 6;

   logic          clk = 1'b0;
   logic          rst;
   logic          a_start, b_start;
   logic [AW-1:0] a_seed;
   logic [BW-1:0] b_seed;
   logic          a_busy, a_done, b_busy, b_done;

   psi_inv_gen_if #(.WIDTH(AW), .IDXW(AIW)) if_a ();
   psi_inv_gen_if #(.WIDTH(BW), .IDXW(BIW)) if_b ();

   psi_inv_gen #(.WIDTH(AW), .Q(AQ), .N(AN)) dut_a (
      .clk(clk), .rst(rst), .start_i(a_start), .psi_inv_i(a_seed),
      .out_if(if_a.master), .busy_o(a_busy), .done_o(a_done)
   );

   psi_inv_gen #(.WIDTH(BW), .Q(BQ), .N(BN)) dut_b (
      .clk(clk), .rst(rst), .start_i(b_start), .psi_inv_i(b_seed),
      .out_if(if_b.master), .busy_o(b_busy), .done_o(b_done)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int got_data[$], got_idx[$], got_cyc[$];
   int vdata[$], vidx[$];
   int done_cyc, done_busy, busy_gap;

   function automatic int pow_mod(input int b, input int e, input int q);
      longint r;
      r = 1;
      for (int i = 0; i < e; i++) r = (r * longint'(b)) % longint'(q);
      return int'(r);
   endfunction

   // Caller is at a negedge; start is raised for the current cycle (relative cycle 0).
   // mode: 0 ready high, 1 random ready, 2 stall 10 cycles at k=3,
   //       3 stray start at k=2, 4 return mid-MUL for k=5.
   task automatic drive(input bit sel, input int seed, input int mode);
      int  cyc, stall, d, k;
      bit  fin, v, bz, dn, rdy;
      got_data.delete(); got_idx.delete(); got_cyc.delete();
      vdata.delete(); vidx.delete();
      done_cyc = -1; done_busy = 1; busy_gap = 0; stall = 0; fin = 0;
      if (sel) begin b_seed = BW'(seed); b_start = 1'b1; end
      else begin a_seed = AW'(seed); a_start = 1'b1; end
      @(negedge clk);
      cyc = 1;
      a_start = 1'b0; b_start = 1'b0;
      a_seed = AW'(seed + 1); b_seed = BW'(seed + 1);
      while (!fin) begin
         v  = sel ? if_b.out_valid : if_a.out_valid;
         d  = sel ? int'(if_b.out_data) : int'(if_a.out_data);
         k  = sel ? int'(if_b.out_idx) : int'(if_a.out_idx);
         bz = sel ? b_busy : a_busy;
         dn = sel ? b_done : a_done;
         if (dn) begin
            done_cyc = cyc; done_busy = int'(bz); fin = 1;
         end else if (cyc >= 6000) begin
            fin = 1;
         end else if (mode == 4 && got_cyc.size() == 5 && cyc >= got_cyc[4] + 3) begin
            fin = 1;
         end else begin
            if (!bz) busy_gap++;
            if (v) begin vdata.push_back(d); vidx.push_back(k); end
            case (mode)
               1: rdy = 1'($urandom_range(0, 1));
               2: if (v && k == 3 && stall < 10) begin rdy = 0; stall++; end else rdy = 1;
               default: rdy = 1;
            endcase
            if (sel) if_b.out_ready = rdy; else if_a.out_ready = rdy;
            if (mode == 3) begin a_start = v && k == 2; a_seed = AW'(3); end
            if (v && rdy) begin got_data.push_back(d); got_idx.push_back(k); got_cyc.push_back(cyc); end
            @(negedge clk);
            cyc++;
         end
      end
      a_start = 1'b0; b_start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; a_start = 0; b_start = 0; a_seed = '0; b_seed = '0;
      if_a.out_ready = 0; if_b.out_ready = 0;
      repeat (3) @(negedge clk);
      n_tests++;
      if ({if_a.out_valid, a_busy, a_done} !== 3'b000) begin
         n_fail++; $display("FAIL reset_a_ctrl: got %b want 000", {if_a.out_valid, a_busy, a_done});
      end
      n_tests++;
      if ({if_a.out_data, if_a.out_idx} !== '0) begin
         n_fail++; $display("FAIL reset_a_data: got %0d/%0d want 0/0", if_a.out_data, if_a.out_idx);
      end
      n_tests++;
      if ({if_b.out_valid, b_busy, b_done, if_b.out_data, if_b.out_idx} !== '0) begin
         n_fail++; $display("FAIL reset_b: got v%b b%b d%b data %0d idx %0d want all 0",
                            if_b.out_valid, b_busy, b_done, if_b.out_data, if_b.out_idx);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_tests++;
      if ({if_a.out_valid, a_busy} !== 2'b00) begin
         n_fail++; $display("FAIL idle_no_start: got %b want 00", {if_a.out_valid, a_busy});
      end
   endtask

   task automatic test_basic();
      drive(0, 2, 0);
      n_tests++;
      if (got_data.size() != AN || vdata.size() != AN) begin
         n_fail++; $display("FAIL basic_count: got %0d hs %0d valid want %0d", got_data.size(), vdata.size(), AN);
      end
      for (int k = 0; k < got_data.size() && k < AN; k++) begin
         n_tests++;
         if (got_data[k] !== pow_mod(2, k, AQ) || got_idx[k] !== k || got_cyc[k] !== 1 + k * (AW + 1)) begin
            n_fail++; $display("FAIL basic_k%0d: got data %0d idx %0d cyc %0d want %0d %0d %0d", k,
                               got_data[k], got_idx[k], got_cyc[k], pow_mod(2, k, AQ), k, 1 + k * (AW + 1));
         end
      end
      n_tests++;
      if (done_cyc !== 2 + (AN - 1) * (AW + 1) || done_busy !== 0 || busy_gap !== 0) begin
         n_fail++; $display("FAIL basic_done: got cyc %0d busy %0d gap %0d want %0d 0 0",
                            done_cyc, done_busy, busy_gap, 2 + (AN - 1) * (AW + 1));
      end
      @(negedge clk);
      n_tests++;
      if ({a_done, a_busy} !== 2'b00) begin
         n_fail++; $display("FAIL done_pulse_width: got %b want 00", {a_done, a_busy});
      end
   endtask

   task automatic test_backpressure();
      int held;
      drive(0, 2, 2);
      held = 0;
      for (int i = 0; i < vidx.size(); i++) if (vidx[i] == 3 && vdata[i] == pow_mod(2, 3, AQ)) held++;
      n_tests++;
      if (held !== 11 || vdata.size() !== AN + 10) begin
         n_fail++; $display("FAIL bp_hold: got %0d held %0d valid want 11 %0d", held, vdata.size(), AN + 10);
      end
      for (int k = 0; k < got_data.size() && k < AN; k++) begin
         n_tests++;
         if (got_data[k] !== pow_mod(2, k, AQ) || got_idx[k] !== k ||
             got_cyc[k] !== 1 + k * (AW + 1) + (k >= 3 ? 10 : 0)) begin
            n_fail++; $display("FAIL bp_k%0d: got %0d idx %0d cyc %0d want %0d", k,
                               got_data[k], got_idx[k], got_cyc[k], pow_mod(2, k, AQ));
         end
      end
      n_tests++;
      if (got_data.size() != AN || done_cyc !== 12 + (AN - 1) * (AW + 1)) begin
         n_fail++; $display("FAIL bp_done: got %0d hs cyc %0d want %0d %0d", got_data.size(), done_cyc,
                            AN, 12 + (AN - 1) * (AW + 1));
      end
   endtask

   task automatic test_ignored_start();
      @(negedge clk);
      drive(0, 2, 3);
      n_tests++;
      if (got_data.size() != AN || done_cyc !== 2 + (AN - 1) * (AW + 1)) begin
         n_fail++; $display("FAIL ign_count: got %0d hs done %0d want %0d", got_data.size(), done_cyc, AN);
      end
      for (int k = 0; k < got_data.size() && k < AN; k++) begin
         n_tests++;
         if (got_data[k] !== pow_mod(2, k, AQ)) begin
            n_fail++; $display("FAIL ign_k%0d: got %0d want %0d", k, got_data[k], pow_mod(2, k, AQ));
         end
      end
   endtask

   task automatic test_mid_reset();
      @(negedge clk);
      drive(0, 2, 4);
      rst = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({if_a.out_valid, a_busy, a_done, if_a.out_data, if_a.out_idx} !== '0) begin
         n_fail++; $display("FAIL midrst_out: got v%b b%b d%b data %0d idx %0d want all 0",
                            if_a.out_valid, a_busy, a_done, if_a.out_data, if_a.out_idx);
      end
      rst = 1'b0;
      @(negedge clk);
      drive(0, 3, 0);
      n_tests++;
      if (got_data.size() != AN || got_cyc[0] !== 1) begin
         n_fail++; $display("FAIL midrst_restart: got %0d hs first cyc %0d want %0d 1", got_data.size(),
                            got_cyc.size() > 0 ? got_cyc[0] : -1, AN);
      end
      for (int k = 0; k < got_data.size() && k < AN; k++) begin
         n_tests++;
         if (got_data[k] !== pow_mod(3, k, AQ) || got_idx[k] !== k) begin
            n_fail++; $display("FAIL midrst_k%0d: got %0d idx %0d want %0d", k, got_data[k], got_idx[k],
                               pow_mod(3, k, AQ));
         end
      end
   endtask

   task automatic test_edge_values();
      int bad;
      @(negedge clk);
      drive(1, BQ - 1, 0);
      bad = 0;
      for (int k = 0; k < got_data.size(); k++) if (got_data[k] !== ((k % 2 == 0) ? 1 : BQ - 1)) bad++;
      n_tests++;
      if (bad != 0 || got_data.size() != BN) begin
         n_fail++; $display("FAIL edge_minus1: got %0d wrong of %0d want 0 of %0d", bad, got_data.size(), BN);
      end
      n_tests++;
      if (done_cyc !== 2 + (BN - 1) * (BW + 1)) begin
         n_fail++; $display("FAIL edge_latency: got %0d want %0d", done_cyc, 2 + (BN - 1) * (BW + 1));
      end
      @(negedge clk);
      drive(1, 1, 0);
      bad = 0;
      for (int k = 0; k < got_data.size(); k++) if (got_data[k] !== 1 || got_idx[k] !== k) bad++;
      n_tests++;
      if (bad != 0 || got_data.size() != BN) begin
         n_fail++; $display("FAIL edge_ones: got %0d wrong of %0d want 0 of %0d", bad, got_data.size(), BN);
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      drive(0, 2, 0);
      drive(0, 3, 0);
      n_tests++;
      if (got_data.size() != AN || got_cyc[0] !== 1) begin
         n_fail++; $display("FAIL b2b_accept: got %0d hs first cyc %0d want %0d 1", got_data.size(),
                            got_cyc.size() > 0 ? got_cyc[0] : -1, AN);
      end
      for (int k = 0; k < got_data.size() && k < AN; k++) begin
         n_tests++;
         if (got_data[k] !== pow_mod(3, k, AQ)) begin
            n_fail++; $display("FAIL b2b_k%0d: got %0d want %0d", k, got_data[k], pow_mod(3, k, AQ));
         end
      end
   endtask

   task automatic test_random();
      int seed, psi, bad;
      for (int r = 0; r < 4; r++) begin
         seed = int'($urandom_range(0, AQ - 1));
         @(negedge clk);
         drive(0, seed, 1);
         bad = 0;
         for (int k = 0; k < got_data.size(); k++)
            if (got_data[k] !== pow_mod(seed, k, AQ) || got_idx[k] !== k) bad++;
         n_tests++;
         if (bad != 0 || got_data.size() != AN || done_cyc < 0 || done_busy !== 0) begin
            n_fail++; $display("FAIL rand_a seed %0d: got %0d wrong %0d hs done %0d want 0 %0d done",
                               seed, bad, got_data.size(), done_cyc, AN);
         end
      end
      seed = int'($urandom_range(AQ, 31));
      @(negedge clk);
      drive(0, seed, 1);
      bad = 0;
      for (int k = 0; k < got_idx.size(); k++) if (got_idx[k] !== k) bad++;
      n_tests++;
      if (bad != 0 || got_idx.size() != AN || done_cyc < 0) begin
         n_fail++; $display("FAIL rand_badseed %0d: got %0d hs %0d misordered done %0d want %0d", seed,
                            got_idx.size(), bad, done_cyc, AN);
      end
      for (int r = 0; r < 2; r++) begin
         seed = int'($urandom_range(1, BQ - 1));
         psi  = pow_mod(seed, BQ - 2, BQ);
         @(negedge clk);
         drive(1, seed, 1);
         bad = 0;
         for (int k = 0; k < got_data.size(); k++) begin
            if (got_data[k] !== pow_mod(seed, k, BQ)) bad++;
            if ((longint'(got_data[k]) * longint'(pow_mod(psi, k, BQ))) % BQ != 1) bad++;
         end
         n_tests++;
         if (bad != 0 || got_data.size() != BN || done_cyc < 0) begin
            n_fail++; $display("FAIL rand_b seed %0d: got %0d wrong %0d hs want 0 %0d", seed, bad,
                               got_data.size(), BN);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_ignored_start();
      test_mid_reset();
      test_edge_values();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
